// File: rtl/insn_halfword_buffer.sv
// Halfword parcel FIFO between fetch and decode. It accepts up to two 16-bit
// parcels per cycle and presents one reassembled RV32 (or compressed) instruction.
module insn_halfword_buffer #(
  parameter int ENTRY_COUNT = 8,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          write_low,
  input  logic [ADDR_WIDTH-1:0]         write_low_pc,
  input  logic [15:0]                   write_low_insn,
  input  logic                          write_low_fault,
  input  logic                          write_high,
  input  logic [ADDR_WIDTH-1:0]         write_high_pc,
  input  logic [15:0]                   write_high_insn,
  input  logic                          write_high_fault,
  output logic [$clog2(ENTRY_COUNT):0]  writable_entry_count,
  output logic                          read_valid,
  input  logic                          read_ready,
  output logic [ADDR_WIDTH-1:0]         read_pc,
  output logic [31:0]                   read_insn,
  output logic                          read_compressed,
  output logic                          read_fault
);

  localparam int PTR_W = $clog2(ENTRY_COUNT);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [15:0]           insn;
    logic                  fault;
  } parcel_t;

  parcel_t          r_mem [ENTRY_COUNT];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  parcel_t          w_h0;
  parcel_t          w_h1;
  logic             w_h0_compressed;
  logic [1:0]       w_n_w;
  logic [1:0]       w_n_r;
  logic [CNT_W-1:0] w_free;
  logic             w_write_ok;
  logic             w_pop;
  logic             w_valid;
  logic             w_compressed;
  logic             w_fault;
  logic [PTR_W-1:0] w_tail_p1;
  logic [CNT_W-1:0] w_count_add;
  logic [CNT_W-1:0] w_count_sub;

  assign w_h0            = r_mem[r_head];
  assign w_h1            = r_mem[r_head + PTR_W'(1)];
  assign w_h0_compressed = (w_h0.insn[1:0] != 2'b11);
  assign w_tail_p1       = r_tail + PTR_W'(1);

  // Free space comes from registered state only, so a same-cycle pop never
  // makes room for a same-cycle write.
  assign w_free     = CNT_W'(ENTRY_COUNT) - r_count;
  assign w_n_w      = {1'b0, write_low} + {1'b0, write_high};
  assign w_write_ok = !flush && (CNT_W'(w_n_w) <= w_free);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_valid      = 1'b0;
    w_compressed = 1'b0;
    w_fault      = 1'b0;
    w_n_r        = 2'd0;
    if (r_count == '0) begin
      w_valid = 1'b0;
    end else if (w_h0.fault) begin
      // A faulted head issues alone; decode only needs the trap, not h1.
      w_valid      = 1'b1;
      w_compressed = w_h0_compressed;
      w_fault      = 1'b1;
      w_n_r        = 2'd1;
    end else if (w_h0_compressed) begin
      w_valid      = 1'b1;
      w_compressed = 1'b1;
      w_n_r        = 2'd1;
    end else if (r_count >= CNT_W'(2)) begin
      w_valid = 1'b1;
      w_fault = w_h1.fault;
      w_n_r   = 2'd2;
    end
    if (flush) begin
      w_valid = 1'b0;
    end
  end

  assign w_pop       = w_valid && read_ready;
  assign w_count_add = w_write_ok ? CNT_W'(w_n_w) : '0;
  assign w_count_sub = w_pop ? CNT_W'(w_n_r) : '0;

  assign writable_entry_count = w_free;
  assign read_valid           = w_valid;
  assign read_pc              = w_h0.pc;
  assign read_insn            = w_compressed ? {16'h0000, w_h0.insn} : {w_h1.insn, w_h0.insn};
  assign read_compressed      = w_compressed;
  assign read_fault           = w_fault;

  // NOTE: the parcel storage has no reset; occupancy is tracked by the
  // pointers and count, so stale slot contents are never observed.
  always_ff @(posedge clk) begin
    if (rst && w_write_ok) begin
      if (write_low) begin
        r_mem[r_tail] <= '{pc: write_low_pc, insn: write_low_insn, fault: write_low_fault};
      end
      if (write_high) begin
        r_mem[write_low ? w_tail_p1 : r_tail] <=
          '{pc: write_high_pc, insn: write_high_insn, fault: write_high_fault};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_write_ok) begin
        r_tail <= r_tail + PTR_W'(w_n_w);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(w_n_r);
      end
      r_count <= r_count + w_count_add - w_count_sub;
    end
  end

endmodule

// File: tb/tb_insn_halfword_buffer.sv
// Self-checking bench for insn_halfword_buffer: directed scenarios followed by
// random traffic, all compared against a parcel-queue reference model.
module tb_insn_halfword_buffer;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        write_low = 1'b0;
  logic [31:0] write_low_pc = '0;
  logic [15:0] write_low_insn = '0;
  logic        write_low_fault = 1'b0;
  logic        write_high = 1'b0;
  logic [31:0] write_high_pc = '0;
  logic [15:0] write_high_insn = '0;
  logic        write_high_fault = 1'b0;
  logic [3:0]  writable_entry_count;
  logic        read_valid;
  logic        read_ready = 1'b0;
  logic [31:0] read_pc;
  logic [31:0] read_insn;
  logic        read_compressed;
  logic        read_fault;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] insn;
    logic        fault;
  } parcel_t;

  parcel_t q[$];

  insn_halfword_buffer #(.ENTRY_COUNT(N), .ADDR_WIDTH(32)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .write_low            (write_low),
    .write_low_pc         (write_low_pc),
    .write_low_insn       (write_low_insn),
    .write_low_fault      (write_low_fault),
    .write_high           (write_high),
    .write_high_pc        (write_high_pc),
    .write_high_insn      (write_high_insn),
    .write_high_fault     (write_high_fault),
    .writable_entry_count (writable_entry_count),
    .read_valid           (read_valid),
    .read_ready           (read_ready),
    .read_pc              (read_pc),
    .read_insn            (read_insn),
    .read_compressed      (read_compressed),
    .read_fault           (read_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // What decode should see, derived from the parcel queue and the RV32 length rule.
  function automatic void model_read(output logic v, output logic c, output logic f,
                                     output logic [31:0] pc, output logic [31:0] insn,
                                     output int n, output logic insn_known);
    v = 0; c = 0; f = 0; pc = '0; insn = '0; n = 0; insn_known = 0;
    if (q.size() == 0) return;
    c  = (q[0].insn[1:0] != 2'b11);
    pc = q[0].pc;
    if (q[0].fault) begin
      v = 1; f = 1; n = 1;
    end else if (c) begin
      v = 1; n = 1;
    end else if (q.size() >= 2) begin
      v = 1; f = q[1].fault; n = 2;
    end
    if (c) begin
      insn = {16'h0000, q[0].insn};
      insn_known = 1;
    end else if (q.size() >= 2) begin
      insn = {q[1].insn, q[0].insn};
      insn_known = 1;
    end
  endfunction

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    logic ev, ec, ef, known;
    logic [31:0] epc, einsn;
    int n, nw, free;
    @(negedge clk);
    model_read(ev, ec, ef, epc, einsn, n, known);
    if (flush) ev = 0;
    if (rst) begin
      check("writable", 64'(writable_entry_count), 64'(N - q.size()));
      check("read_valid", 64'(read_valid), 64'(ev));
      if (ev) begin
        check("read_pc", 64'(read_pc), 64'(epc));
        check("read_compressed", 64'(read_compressed), 64'(ec));
        check("read_fault", 64'(read_fault), 64'(ef));
        if (known) check("read_insn", 64'(read_insn), 64'(einsn));
      end
    end
    @(posedge clk);
    if (!rst || flush) begin
      q.delete();
    end else begin
      free = N - q.size();
      nw = int'(write_low) + int'(write_high);
      if (ev && read_ready) begin
        for (int i = 0; i < n; i++) void'(q.pop_front());
      end
      if (nw <= free) begin
        if (write_low)  q.push_back('{write_low_pc, write_low_insn, write_low_fault});
        if (write_high) q.push_back('{write_high_pc, write_high_insn, write_high_fault});
      end
    end
    #1;
  endtask

  task automatic set_w(input logic lo, input logic [31:0] lpc, input logic [15:0] li, input logic lf,
                       input logic hi, input logic [31:0] hpc, input logic [15:0] hin, input logic hf);
    write_low = lo;  write_low_pc = lpc;  write_low_insn = li;   write_low_fault = lf;
    write_high = hi; write_high_pc = hpc; write_high_insn = hin; write_high_fault = hf;
  endtask

  task automatic idle_w();
    set_w(0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic push_pair(input logic [31:0] pc, input logic [15:0] lo, input logic [15:0] hi);
    set_w(1, pc, lo, 0, 1, pc + 2, hi, 0);
    step();
    idle_w();
  endtask

  logic [31:0] hold_pc, hold_insn;
  logic        hold_c, hold_f;
  logic [31:0] drain_exp [6] = '{32'h0000_0001, 32'h0000_0002, 32'h1234_0003,
                                 32'h0000_0005, 32'h1111_0007, 32'h0000_0009};
  logic [31:0] fpc;

  initial begin
    // Reset, then idle.
    rst = 0; step(); step();
    rst = 1;
    for (int i = 0; i < 5; i++) step();
    check("idle_valid", 64'(read_valid), 64'd0);
    check("idle_free", 64'(writable_entry_count), 64'd8);

    // Two compressed parcels in one write, drained one per cycle.
    read_ready = 1;
    set_w(1, 32'h100, 16'h0001, 0, 1, 32'h102, 16'h4501, 0);
    step(); idle_w();
    check("c1_insn", 64'(read_insn), 64'h0000_0001);
    check("c1_pc", 64'(read_pc), 64'h100);
    step();
    check("c2_insn", 64'(read_insn), 64'h0000_4501);
    check("c2_pc", 64'(read_pc), 64'h102);
    step();
    check("c3_valid", 64'(read_valid), 64'd0);

    // 32-bit instruction whose halves arrive in separate writes.
    set_w(1, 32'h200, 16'h0093, 0, 0, '0, '0, 0);
    step(); idle_w();
    check("split_wait_valid", 64'(read_valid), 64'd0);
    check("split_wait_free", 64'(writable_entry_count), 64'd7);
    set_w(1, 32'h202, 16'h0010, 0, 0, '0, '0, 0);
    step(); idle_w();
    check("split_insn", 64'(read_insn), 64'h0010_0093);
    check("split_pc", 64'(read_pc), 64'h200);
    check("split_comp", 64'(read_compressed), 64'd0);
    step();

    // Move head to slot 7, then a 32-bit pair wrapping 7->0 with a high-parcel fault.
    flush = 1; step(); flush = 0;
    for (int i = 0; i < 3; i++) push_pair(32'h400 + 32'(4 * i), 16'h0001, 16'h0001);
    set_w(1, 32'h40c, 16'h0001, 0, 0, '0, '0, 0); step(); idle_w();
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    check("prefill_empty", 64'(read_valid), 64'd0);
    set_w(1, 32'h300, 16'h0513, 0, 1, 32'h302, 16'h0000, 1);
    step(); idle_w();
    check("wrap_insn", 64'(read_insn), 64'h0000_0513);
    check("wrap_fault", 64'(read_fault), 64'd1);
    check("wrap_pc", 64'(read_pc), 64'h300);
    check("wrap_comp", 64'(read_compressed), 64'd0);
    step();
    check("wrap_consumed2_valid", 64'(read_valid), 64'd0);
    check("wrap_consumed2_free", 64'(writable_entry_count), 64'd8);

    // Backpressure until full; a fifth write is dropped.
    read_ready = 0;
    push_pair(32'h500, 16'h0001, 16'h0002);
    push_pair(32'h504, 16'h0003, 16'h1234);
    push_pair(32'h508, 16'h0005, 16'h0007);
    push_pair(32'h50c, 16'h1111, 16'h0009);
    check("full_free", 64'(writable_entry_count), 64'd0);
    push_pair(32'h510, 16'haaaa, 16'hbbbb);
    check("drop_free", 64'(writable_entry_count), 64'd0);
    check("drop_head", 64'(read_insn), 64'h0000_0001);
    hold_pc = read_pc; hold_insn = read_insn; hold_c = read_compressed; hold_f = read_fault;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 64'(read_valid), 64'd1);
      check("stall_pc", 64'(read_pc), 64'(hold_pc));
      check("stall_insn", 64'(read_insn), 64'(hold_insn));
      check("stall_comp", 64'(read_compressed), 64'(hold_c));
      check("stall_fault", 64'(read_fault), 64'(hold_f));
    end
    read_ready = 1;
    for (int i = 0; i < 6; i++) begin
      check("drain_insn", 64'(read_insn), 64'(drain_exp[i]));
      step();
    end
    check("drain_done_valid", 64'(read_valid), 64'd0);
    check("drain_done_free", 64'(writable_entry_count), 64'd8);

    // Flush while full, with ready high and a write in the same cycle.
    read_ready = 0;
    for (int i = 0; i < 4; i++) push_pair(32'h600 + 32'(4 * i), 16'h0001, 16'h0001);
    check("refill_free", 64'(writable_entry_count), 64'd0);
    read_ready = 1; flush = 1;
    set_w(1, 32'h700, 16'h0001, 0, 1, 32'h702, 16'h0001, 0);
    step();
    flush = 0; idle_w();
    check("flush_valid", 64'(read_valid), 64'd0);
    check("flush_free", 64'(writable_entry_count), 64'd8);

    // Random traffic from a well-behaved writer.
    fpc = 32'h1000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int nw, free;
      logic [15:0] a, b;
      free = N - q.size();
      nw = int'($urandom_range(0, 2));
      if (nw > free) nw = free;
      a = 16'($urandom); b = 16'($urandom);
      if (nw == 2) begin
        set_w(1, fpc, a, ($urandom_range(0, 7) == 0), 1, fpc + 2, b, ($urandom_range(0, 7) == 0));
      end else if (nw == 1) begin
        if ($urandom_range(0, 1) == 1) set_w(1, fpc, a, ($urandom_range(0, 7) == 0), 0, '0, '0, 0);
        else                           set_w(0, '0, '0, 0, 1, fpc, a, ($urandom_range(0, 7) == 0));
      end else begin
        idle_w();
      end
      fpc = fpc + 32'(2 * nw);
      read_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 99) != 0);
      step();
    end
    rst = 1; flush = 0; idle_w(); read_ready = 1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
